// File: rtl/id_operand_stage_if.sv
// Operand-stage bus: decode request, register-file data, EX/MEM forwarding
// sources, flush and both handshakes. The stage uses the slave modport.
interface id_operand_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned OP_W   = 8
);
    logic              i_valid;
    logic              o_ready;
    logic              i_readEnableLeft;
    logic              i_readEnableRight;
    logic [REG_AW-1:0] i_addrLeft;
    logic [REG_AW-1:0] i_addrRight;
    logic [DATA_W-1:0] i_immediate;
    logic [OP_W-1:0]   i_exop;
    logic [REG_AW-1:0] i_dest;
    logic              i_isLoad;
    logic [DATA_W-1:0] i_readValueLeft;
    logic [DATA_W-1:0] i_readValueRight;
    logic              i_exWriteEnable;
    logic [REG_AW-1:0] i_exDest;
    logic [DATA_W-1:0] i_exValue;
    logic              i_exIsLoad;
    logic              i_memWriteEnable;
    logic [REG_AW-1:0] i_memDest;
    logic [DATA_W-1:0] i_memValue;
    logic              i_flush;
    logic              i_downReady;
    logic              o_valid;
    logic [DATA_W-1:0] o_srcLeft;
    logic [DATA_W-1:0] o_srcRight;
    logic [OP_W-1:0]   o_exop;
    logic [REG_AW-1:0] o_dest;
    logic              o_isLoad;
    logic              o_stall;

    modport master (
        output i_valid, i_readEnableLeft, i_readEnableRight, i_addrLeft, i_addrRight,
               i_immediate, i_exop, i_dest, i_isLoad, i_readValueLeft, i_readValueRight,
               i_exWriteEnable, i_exDest, i_exValue, i_exIsLoad,
               i_memWriteEnable, i_memDest, i_memValue, i_flush, i_downReady,
        input  o_ready, o_valid, o_srcLeft, o_srcRight, o_exop, o_dest, o_isLoad, o_stall
    );

    modport slave (
        input  i_valid, i_readEnableLeft, i_readEnableRight, i_addrLeft, i_addrRight,
               i_immediate, i_exop, i_dest, i_isLoad, i_readValueLeft, i_readValueRight,
               i_exWriteEnable, i_exDest, i_exValue, i_exIsLoad,
               i_memWriteEnable, i_memDest, i_memValue, i_flush, i_downReady,
        output o_ready, o_valid, o_srcLeft, o_srcRight, o_exop, o_dest, o_isLoad, o_stall
    );
endinterface

// File: rtl/id_operand_stage.sv
// ID/EX operand stage: EX/MEM forwarding, load-use interlock, ID/EX register.
// Optional stall-cycle counter enabled by defining ID_STALL_COUNTER_EN.
module id_operand_stage #(
    parameter int unsigned     DATA_W = 32,
    parameter int unsigned     REG_AW = 5,
    parameter int unsigned     OP_W   = 8,
    parameter logic [OP_W-1:0] NOP_OP = '0
`ifdef ID_STALL_COUNTER_EN
    ,
    parameter int unsigned     CNT_W  = 16
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    id_operand_stage_if.slave bus
`ifdef ID_STALL_COUNTER_EN
    ,
    output logic [CNT_W-1:0]  o_stallCycles
`endif
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] src_left_q, src_left_d;
    logic [DATA_W-1:0] src_right_q, src_right_d;
    logic [OP_W-1:0]   exop_q, exop_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic              is_load_q, is_load_d;

    logic [DATA_W-1:0] sel_left, sel_right;
    logic              hazard_left, hazard_right, stall, load, transfer;

    function automatic logic [DATA_W-1:0] select_operand(
        input logic              en,
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] rf_value,
        input logic [DATA_W-1:0] imm,
        input logic              ex_we,
        input logic [REG_AW-1:0] ex_dest,
        input logic [DATA_W-1:0] ex_value,
        input logic              mem_we,
        input logic [REG_AW-1:0] mem_dest,
        input logic [DATA_W-1:0] mem_value
    );
        if (!en)                            return imm;
        else if (addr == '0)                return '0;
        else if (ex_we && ex_dest == addr)  return ex_value;
        else if (mem_we && mem_dest == addr) return mem_value;
        else                                return rf_value;
    endfunction

    always_comb begin
        sel_left  = select_operand(bus.i_readEnableLeft, bus.i_addrLeft, bus.i_readValueLeft,
                                   bus.i_immediate, bus.i_exWriteEnable, bus.i_exDest, bus.i_exValue,
                                   bus.i_memWriteEnable, bus.i_memDest, bus.i_memValue);
        sel_right = select_operand(bus.i_readEnableRight, bus.i_addrRight, bus.i_readValueRight,
                                   bus.i_immediate, bus.i_exWriteEnable, bus.i_exDest, bus.i_exValue,
                                   bus.i_memWriteEnable, bus.i_memDest, bus.i_memValue);

        // A load in EX has no data yet, so a consumer of its dest must wait.
        hazard_left  = bus.i_readEnableLeft && (bus.i_addrLeft != '0) && bus.i_exWriteEnable
                       && bus.i_exIsLoad && (bus.i_exDest == bus.i_addrLeft);
        hazard_right = bus.i_readEnableRight && (bus.i_addrRight != '0) && bus.i_exWriteEnable
                       && bus.i_exIsLoad && (bus.i_exDest == bus.i_addrRight);
        stall    = hazard_left || hazard_right;
        load     = (!valid_q || bus.i_downReady) && !stall && !bus.i_flush;
        transfer = bus.i_valid && load;
    end

    always_comb begin
        valid_d     = valid_q;
        src_left_d  = src_left_q;
        src_right_d = src_right_q;
        exop_d      = exop_q;
        dest_d      = dest_q;
        is_load_d   = is_load_q;
        if (bus.i_flush) begin
            valid_d = 1'b0;
            exop_d  = NOP_OP;
            dest_d  = '0;
        end else if (transfer) begin
            valid_d     = 1'b1;
            src_left_d  = sel_left;
            src_right_d = sel_right;
            exop_d      = bus.i_exop;
            dest_d      = bus.i_dest;
            is_load_d   = bus.i_isLoad;
        end else if (!valid_q || bus.i_downReady) begin
            valid_d = 1'b0;
            exop_d  = NOP_OP;
            dest_d  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q     <= 1'b0;
            src_left_q  <= '0;
            src_right_q <= '0;
            exop_q      <= NOP_OP;
            dest_q      <= '0;
            is_load_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            src_left_q  <= src_left_d;
            src_right_q <= src_right_d;
            exop_q      <= exop_d;
            dest_q      <= dest_d;
            is_load_q   <= is_load_d;
        end
    end

    assign bus.o_ready    = load;
    assign bus.o_stall    = stall;
    assign bus.o_valid    = valid_q;
    assign bus.o_srcLeft  = src_left_q;
    assign bus.o_srcRight = src_right_q;
    assign bus.o_exop     = exop_q;
    assign bus.o_dest     = dest_q;
    assign bus.o_isLoad   = is_load_q;

`ifdef ID_STALL_COUNTER_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.i_valid && stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign o_stallCycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed vector table, hand-written
// backpressure/reset/counter sequences, then random traffic against a reference model.
module tb_id_operand_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_operand_stage_if #(.DATA_W(32), .REG_AW(5), .OP_W(8)) bus ();

`ifdef ID_STALL_COUNTER_EN
    logic [15:0] stall_cycles;
`endif

    id_operand_stage #(
        .DATA_W(32),
        .REG_AW(5),
        .OP_W  (8),
        .NOP_OP(8'h00)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
`ifdef ID_STALL_COUNTER_EN
        ,
        .o_stallCycles(stall_cycles)
`endif
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model state: contents of the ID/EX slot.
    logic        m_valid;
    logic [31:0] m_l, m_r;
    logic [7:0]  m_exop;
    logic [4:0]  m_dest;
    logic        m_ld;
    int unsigned m_cnt;

    typedef struct {
        logic valid, en_l, en_r;
        logic [4:0] a_l, a_r;
        logic [31:0] imm;
        logic [7:0] exop;
        logic [4:0] dest;
        logic is_load;
        logic [31:0] rf_l, rf_r;
        logic ex_we;
        logic [4:0] ex_dest;
        logic [31:0] ex_val;
        logic ex_ld;
        logic mem_we;
        logic [4:0] mem_dest;
        logic [31:0] mem_val;
        logic flush, down;
        logic x_stall, x_ready, x_valid;
        logic [31:0] x_l, x_r;
        logic [7:0] x_exop;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Value an instruction would see for one operand: immediate, hardwired zero,
    // youngest in-flight producer (EX before MEM), else the register file.
    function automatic logic [31:0] resolve(input logic en, input logic [4:0] a, input logic [31:0] rf);
        logic        pw[2];
        logic [4:0]  pd[2];
        logic [31:0] pv[2];
        if (!en) return bus.i_immediate;
        if (a == 5'd0) return 32'd0;
        pw[0] = bus.i_exWriteEnable;  pd[0] = bus.i_exDest;  pv[0] = bus.i_exValue;
        pw[1] = bus.i_memWriteEnable; pd[1] = bus.i_memDest; pv[1] = bus.i_memValue;
        for (int k = 0; k < 2; k++) if (pw[k] && pd[k] == a) return pv[k];
        return rf;
    endfunction

    function automatic logic waits_on_load(input logic en, input logic [4:0] a);
        return en && a != 5'd0 && bus.i_exWriteEnable && bus.i_exIsLoad && bus.i_exDest == a;
    endfunction

    function automatic logic m_stall();
        return waits_on_load(bus.i_readEnableLeft, bus.i_addrLeft)
            || waits_on_load(bus.i_readEnableRight, bus.i_addrRight);
    endfunction

    function automatic logic m_ready();
        return (!m_valid || bus.i_downReady) && !m_stall() && !bus.i_flush;
    endfunction

    task automatic m_reset();
        m_valid = 1'b0; m_l = '0; m_r = '0; m_exop = 8'h00; m_dest = '0; m_ld = 1'b0; m_cnt = 0;
    endtask

    task automatic m_update();
        logic slot_free, accepted, stalled;
        slot_free = !m_valid || bus.i_downReady;
        accepted  = bus.i_valid && m_ready();
        stalled   = m_stall();
        if (bus.i_flush) begin
            m_valid = 1'b0; m_exop = 8'h00; m_dest = '0;
        end else if (accepted) begin
            m_l = resolve(bus.i_readEnableLeft, bus.i_addrLeft, bus.i_readValueLeft);
            m_r = resolve(bus.i_readEnableRight, bus.i_addrRight, bus.i_readValueRight);
            m_exop = bus.i_exop; m_dest = bus.i_dest; m_ld = bus.i_isLoad; m_valid = 1'b1;
        end else if (slot_free) begin
            m_valid = 1'b0; m_exop = 8'h00; m_dest = '0;
        end
        if (bus.i_valid && stalled && m_cnt != 32'hFFFF) m_cnt++;
    endtask

    // One clock: check combinational outputs mid-cycle, then registered outputs after the edge.
    task automatic tick();
        @(negedge clk);
        check("stall", 64'(bus.o_stall), 64'(m_stall()));
        check("ready", 64'(bus.o_ready), 64'(m_ready()));
        m_update();
        @(posedge clk);
        #1;
        check("valid",    64'(bus.o_valid),    64'(m_valid));
        check("srcLeft",  64'(bus.o_srcLeft),  64'(m_l));
        check("srcRight", 64'(bus.o_srcRight), 64'(m_r));
        check("exop",     64'(bus.o_exop),     64'(m_exop));
        check("dest",     64'(bus.o_dest),     64'(m_dest));
        check("isLoad",   64'(bus.o_isLoad),   64'(m_ld));
`ifdef ID_STALL_COUNTER_EN
        check("stallCycles", 64'(stall_cycles), 64'(m_cnt));
`endif
    endtask

    task automatic set_idle();
        bus.i_valid = 1'b0; bus.i_readEnableLeft = 1'b0; bus.i_readEnableRight = 1'b0;
        bus.i_addrLeft = '0; bus.i_addrRight = '0; bus.i_immediate = '0; bus.i_exop = '0;
        bus.i_dest = '0; bus.i_isLoad = 1'b0; bus.i_readValueLeft = '0; bus.i_readValueRight = '0;
        bus.i_exWriteEnable = 1'b0; bus.i_exDest = '0; bus.i_exValue = '0; bus.i_exIsLoad = 1'b0;
        bus.i_memWriteEnable = 1'b0; bus.i_memDest = '0; bus.i_memValue = '0;
        bus.i_flush = 1'b0; bus.i_downReady = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        m_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        bus.i_valid = v.valid; bus.i_readEnableLeft = v.en_l; bus.i_readEnableRight = v.en_r;
        bus.i_addrLeft = v.a_l; bus.i_addrRight = v.a_r; bus.i_immediate = v.imm;
        bus.i_exop = v.exop; bus.i_dest = v.dest; bus.i_isLoad = v.is_load;
        bus.i_readValueLeft = v.rf_l; bus.i_readValueRight = v.rf_r;
        bus.i_exWriteEnable = v.ex_we; bus.i_exDest = v.ex_dest; bus.i_exValue = v.ex_val;
        bus.i_exIsLoad = v.ex_ld; bus.i_memWriteEnable = v.mem_we; bus.i_memDest = v.mem_dest;
        bus.i_memValue = v.mem_val; bus.i_flush = v.flush; bus.i_downReady = v.down;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1,1'b1,1'b1, 5'd1,5'd2, 32'h0, 8'h10,5'd3,1'b0, 32'h5,32'h7,
                    1'b1,5'd1,32'h11,1'b0, 1'b0,5'd0,32'h0, 1'b0,1'b1,
                    1'b0,1'b1,1'b1, 32'h11,32'h7,8'h10};
        vecs[1] = '{1'b1,1'b0,1'b1, 5'd0,5'd2, 32'h55, 8'h11,5'd4,1'b0, 32'h0,32'h0,
                    1'b1,5'd2,32'hAA,1'b0, 1'b1,5'd2,32'hBB, 1'b0,1'b1,
                    1'b0,1'b1,1'b1, 32'h55,32'hAA,8'h11};
        vecs[2] = '{1'b1,1'b0,1'b1, 5'd0,5'd2, 32'h55, 8'h12,5'd4,1'b0, 32'h0,32'h0,
                    1'b1,5'd5,32'hAA,1'b0, 1'b1,5'd2,32'hBB, 1'b0,1'b1,
                    1'b0,1'b1,1'b1, 32'h55,32'hBB,8'h12};
        vecs[3] = '{1'b1,1'b1,1'b0, 5'd0,5'd0, 32'h3, 8'h13,5'd6,1'b0, 32'h99,32'h0,
                    1'b1,5'd0,32'hFFFF_FFFF,1'b0, 1'b0,5'd0,32'h0, 1'b0,1'b1,
                    1'b0,1'b1,1'b1, 32'h0,32'h3,8'h13};
        vecs[4] = '{1'b1,1'b1,1'b0, 5'd4,5'd0, 32'h8, 8'h14,5'd7,1'b0, 32'h77,32'h0,
                    1'b1,5'd4,32'h0,1'b1, 1'b0,5'd0,32'h0, 1'b0,1'b1,
                    1'b1,1'b0,1'b0, 32'h0,32'h3,8'h00};
        vecs[5] = '{1'b1,1'b1,1'b0, 5'd4,5'd0, 32'h8, 8'h14,5'd7,1'b0, 32'h77,32'h0,
                    1'b0,5'd4,32'h0,1'b0, 1'b1,5'd4,32'h1234, 1'b0,1'b1,
                    1'b0,1'b1,1'b1, 32'h1234,32'h8,8'h14};
        vecs[6] = '{1'b1,1'b1,1'b0, 5'd1,5'd0, 32'h9, 8'h15,5'd8,1'b0, 32'h0,32'h0,
                    1'b0,5'd0,32'h0,1'b0, 1'b0,5'd0,32'h0, 1'b1,1'b1,
                    1'b0,1'b0,1'b0, 32'h1234,32'h8,8'h00};
        vecs[7] = '{1'b0,1'b0,1'b0, 5'd0,5'd0, 32'h0, 8'h00,5'd0,1'b0, 32'h0,32'h0,
                    1'b0,5'd0,32'h0,1'b0, 1'b0,5'd0,32'h0, 1'b0,1'b1,
                    1'b0,1'b1,1'b0, 32'h1234,32'h8,8'h00};

        do_reset();
        check("reset_valid", 64'(bus.o_valid), 64'd0);
        check("reset_exop",  64'(bus.o_exop),  64'd0);
        check("reset_src",   64'({bus.o_srcLeft, bus.o_srcRight}), 64'd0);

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i]);
            #2;
            check($sformatf("vec%0d_stall", i), 64'(bus.o_stall), 64'(vecs[i].x_stall));
            check($sformatf("vec%0d_ready", i), 64'(bus.o_ready), 64'(vecs[i].x_ready));
            tick();
            check($sformatf("vec%0d_valid", i), 64'(bus.o_valid),    64'(vecs[i].x_valid));
            check($sformatf("vec%0d_left", i),  64'(bus.o_srcLeft),  64'(vecs[i].x_l));
            check($sformatf("vec%0d_right", i), 64'(bus.o_srcRight), 64'(vecs[i].x_r));
            check($sformatf("vec%0d_exop", i),  64'(bus.o_exop),     64'(vecs[i].x_exop));
        end

        // Backpressure: held instruction stays put while a new one waits.
        do_reset();
        bus.i_valid = 1'b1; bus.i_immediate = 32'hA1; bus.i_exop = 8'h21; bus.i_dest = 5'd5;
        tick();
        bus.i_immediate = 32'hB2; bus.i_exop = 8'h22; bus.i_dest = 5'd6; bus.i_downReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_left", 64'(bus.o_srcLeft), 64'h A1);
            check("bp_hold_exop", 64'(bus.o_exop), 64'h21);
            check("bp_ready", 64'(bus.o_ready), 64'd0);
        end
        bus.i_downReady = 1'b1;
        tick();
        check("bp_take_left", 64'(bus.o_srcLeft), 64'hB2);
        check("bp_take_exop", 64'(bus.o_exop), 64'h22);

        // Asynchronous reset while a load-use stall holds a valid instruction.
        bus.i_downReady = 1'b0; bus.i_readEnableLeft = 1'b1; bus.i_addrLeft = 5'd4;
        bus.i_exWriteEnable = 1'b1; bus.i_exDest = 5'd4; bus.i_exIsLoad = 1'b1;
        tick();
        check("midstall_stall", 64'(bus.o_stall), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus.o_valid), 64'd0);
        check("arst_exop",  64'(bus.o_exop),  64'd0);
        check("arst_left",  64'(bus.o_srcLeft), 64'd0);
        check("arst_dest",  64'(bus.o_dest), 64'd0);
        do_reset();

`ifdef ID_STALL_COUNTER_EN
        bus.i_valid = 1'b1; bus.i_readEnableLeft = 1'b1; bus.i_addrLeft = 5'd4;
        bus.i_exWriteEnable = 1'b1; bus.i_exDest = 5'd4; bus.i_exIsLoad = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        set_idle();
        tick();
        check("stall_count3", 64'(stall_cycles), 64'd3);
`endif

        // Random traffic with a narrow register range so forwarding and hazards are frequent.
        for (int n = 0; n < 400; n++) begin
            bus.i_valid = 1'($urandom_range(0, 3) != 0);
            bus.i_readEnableLeft = 1'($urandom_range(0, 3) != 0);
            bus.i_readEnableRight = 1'($urandom_range(0, 3) != 0);
            bus.i_addrLeft = 5'($urandom_range(0, 3));
            bus.i_addrRight = 5'($urandom_range(0, 3));
            bus.i_immediate = $urandom;
            bus.i_exop = 8'($urandom);
            bus.i_dest = 5'($urandom);
            bus.i_isLoad = 1'($urandom);
            bus.i_readValueLeft = $urandom;
            bus.i_readValueRight = $urandom;
            bus.i_exWriteEnable = 1'($urandom);
            bus.i_exDest = 5'($urandom_range(0, 3));
            bus.i_exValue = $urandom;
            bus.i_exIsLoad = 1'($urandom_range(0, 2) == 0);
            bus.i_memWriteEnable = 1'($urandom);
            bus.i_memDest = 5'($urandom_range(0, 3));
            bus.i_memValue = $urandom;
            bus.i_flush = 1'($urandom_range(0, 9) == 0);
            bus.i_downReady = 1'($urandom_range(0, 9) < 7);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised successor to the combinational decode stage.
- Takes decoded operand requests (read enables, register addresses, immediate, exop, dest, load flag) plus register-file read data.
- Resolves data hazards by forwarding from EX and MEM, and inserts load-use interlock bubbles.
- Registers the result into an ID/EX pipeline register with valid/ready handshakes on both sides; sits between decode and EX.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register address width
OP_W, 8, exop width
NOP_OP, 0, exop value driven on reset, flush and bubble
CNT_W, 16, stall counter width (optional feature only)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  upstream instruction valid
o_ready  out  1  stage accepts upstream instruction this cycle
i_readEnableLeft  in  1  left operand from register (else immediate)
i_readEnableRight  in  1  right operand from register (else immediate)
i_addrLeft  in  REG_AW  left source register
i_addrRight  in  REG_AW  right source register
i_immediate  in  DATA_W  immediate for disabled reads
i_exop  in  OP_W  decoded operation
i_dest  in  REG_AW  destination register
i_isLoad  in  1  instruction is a load
i_readValueLeft  in  DATA_W  register-file left data
i_readValueRight  in  DATA_W  register-file right data
i_exWriteEnable  in  1  EX instruction writes a register
i_exDest  in  REG_AW  EX destination
i_exValue  in  DATA_W  EX result
i_exIsLoad  in  1  EX instruction is a load; data not yet available
i_memWriteEnable  in  1  MEM instruction writes a register
i_memDest  in  REG_AW  MEM destination
i_memValue  in  DATA_W  MEM result
i_flush  in  1  kill the held and incoming instruction
i_downReady  in  1  EX accepts output this cycle
o_valid  out  1  output register holds an instruction
o_srcLeft  out  DATA_W  registered left operand
o_srcRight  out  DATA_W  registered right operand
o_exop  out  OP_W  registered exop
o_dest  out  REG_AW  registered destination
o_isLoad  out  1  registered load flag
o_stall  out  1  load-use hazard present this cycle

Behaviour:
- Reset (async, i_rst_n=0): o_valid=0, o_exop=NOP_OP, o_dest=0, o_srcLeft=o_srcRight=0, o_isLoad=0. Takes effect immediately, including mid-stall.
- Operand select (combinational, per side, first match wins):
  - read disabled -> i_immediate
  - address 0 -> 0
  - EX match (i_exWriteEnable, i_exDest==addr) -> i_exValue
  - MEM match -> i_memValue
  - otherwise -> register-file value
- EX has priority over MEM when both match.
- Hazard: a side whose read is enabled, address nonzero, matches EX dest with i_exWriteEnable=1 and i_exIsLoad=1. Either side hazardous -> o_stall=1. Evaluated every cycle.
- Load signal: load = (!o_valid | i_downReady) & !o_stall & !i_flush.
- o_ready = load. Upstream transfer occurs when i_valid & o_ready.
- Register update on each i_clk rising edge, in priority order:
  - i_flush -> o_valid=0, o_exop=NOP_OP, o_dest=0.
  - Transfer -> capture selected operands and i_exop/i_dest/i_isLoad; o_valid=1.
  - (!o_valid | i_downReady), no transfer -> bubble: o_valid=0, o_exop=NOP_OP, o_dest=0.
  - Else -> hold all outputs (backpressure).
- Latency: one cycle from transfer to o_valid.
- Throughput: one instruction per cycle with no hazard and i_downReady=1.
- A load-use stall lasts while the hazard persists: one cycle normally, longer if EX is itself held.
- o_stall is a pure function of current inputs; it is not registered.

Optional Feature:
Macro ID_STALL_COUNTER_EN.
- Defined: adds port o_stallCycles, out, CNT_W.
  - Reset 0.
  - Increments each cycle that i_valid & o_stall.
  - Saturates at all-ones; cleared by reset only.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ADD r3,r1,r2 with EX writing r1=0x11 and regfile r1=0x5 -> next cycle o_srcLeft=0x11, o_valid=1.
- EX writes r2=0xAA, MEM writes r2=0xBB, right read r2 -> o_srcRight=0xAA; with EX not matching -> 0xBB.
- Read r0 while EX writes r0=0xFFFF_FFFF -> o_srcLeft=0.
- EX load to r4 (i_exIsLoad=1), next instruction reads r4:
  - o_stall=1, o_ready=0, bubble with o_exop=NOP_OP.
  - Following cycle with MEM r4=0x1234 -> captured o_srcLeft=0x1234.
- o_valid=1, i_downReady=0 for 3 cycles with new i_valid -> outputs held unchanged, o_ready=0; first i_downReady=1 captures the new instruction.
- i_flush with o_valid=1 and i_valid=1 -> next cycle o_valid=0, o_exop=NOP_OP.
- Async reset mid-stall -> outputs reset immediately.
- ID_STALL_COUNTER_EN: 3 stall cycles -> o_stallCycles=3.
